// File: rtl/display_bcd_loader_if.sv
// CPU-side I/O register bus for the 7-segment display loader.
// The master drives address/strobe/data; the slave returns combinational read data.
interface display_bcd_loader_if;
  logic [2:0] io_addr;
  logic       io_we;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;

  modport master (output io_addr, output io_we, output io_wdata, input io_rdata);
  modport slave  (input io_addr, input io_we, input io_wdata, output io_rdata);
endinterface

// File: rtl/display_bcd_loader.sv
// Display buffer register block with a 16-cycle double-dabble binary-to-BCD loader,
// leading-zero blanking and an overflow ("----") indication.
module display_bcd_loader #(
  parameter logic [7:0] RESET_CODE = 8'h10,
  parameter logic [7:0] OVF_CODE   = 8'h11,
  parameter logic       LZB_RESET  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  display_bcd_loader_if.slave         bus,
  output logic                        display_ctrl,
  output logic [7:0]                  display_buf0,
  output logic [7:0]                  display_buf1,
  output logic [7:0]                  display_buf2,
  output logic [7:0]                  display_buf3,
  output logic                        busy
);
  localparam logic [7:0] BLANK_CODE = 8'h10;

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t      state_q;
  logic [7:0]  buf_q [4];
  logic        raw_q;
  logic        lzb_q;
  logic [7:0]  val_lo_q;
  logic [7:0]  val_hi_q;
  logic        ovf_q;
  logic        busy_q;
  logic [15:0] bcd_q;
  logic [15:0] bin_q;
  logic [4:0]  cnt_q;

  logic [15:0] bcd_adj_d;
  logic [15:0] start_val_d;
  logic [3:0]  lead_zero_d;
  logic [7:0]  code_d [4];

  assign start_val_d = {bus.io_wdata, val_lo_q};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign bcd_adj_d[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    // Digit 0 is the thousands nibble; blanking runs left to right and stops at the first nonzero digit.
    for (gi = 0; gi < 4; gi++) begin : g_code
      if (gi == 0) begin : g_first
        assign lead_zero_d[gi] = lzb_q && (bcd_q[15:12] == 4'd0);
      end else if (gi == 3) begin : g_ones
        assign lead_zero_d[gi] = 1'b0;
      end else begin : g_mid
        assign lead_zero_d[gi] = lead_zero_d[gi-1] && (bcd_q[(3-gi)*4 +: 4] == 4'd0);
      end
      assign code_d[gi] = ovf_q          ? OVF_CODE   :
                          lead_zero_d[gi] ? BLANK_CODE :
                          {4'd0, bcd_q[(3-gi)*4 +: 4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      for (int i = 0; i < 4; i++) buf_q[i] <= RESET_CODE;
      raw_q    <= 1'b0;
      lzb_q    <= LZB_RESET;
      val_lo_q <= 8'd0;
      val_hi_q <= 8'd0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      bcd_q    <= 16'd0;
      bin_q    <= 16'd0;
      cnt_q    <= 5'd0;
    end else begin
      if (bus.io_we) begin
        case (bus.io_addr)
          3'd0, 3'd1, 3'd2, 3'd3: if (!busy_q) buf_q[bus.io_addr[1:0]] <= bus.io_wdata;
          3'd4: begin
            lzb_q <= bus.io_wdata[1];
            if (state_q != WRITE) raw_q <= bus.io_wdata[0];
          end
          3'd5: val_lo_q <= bus.io_wdata;
          default: ;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (bus.io_we && bus.io_addr == 3'd6) begin
            val_hi_q <= bus.io_wdata;
            busy_q   <= 1'b1;
            if (start_val_d <= 16'd9999) begin
              bcd_q   <= 16'd0;
              bin_q   <= start_val_d;
              cnt_q   <= 5'd16;
              ovf_q   <= 1'b0;
              state_q <= SHIFT;
            end else begin
              ovf_q   <= 1'b1;
              state_q <= WRITE;
            end
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj_d[14:0], bin_q[15]};
          bin_q <= {bin_q[14:0], 1'b0};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= WRITE;
        end
        WRITE: begin
          for (int i = 0; i < 4; i++) buf_q[i] <= code_d[i];
          raw_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.io_rdata = 8'd0;
    case (bus.io_addr)
      3'd0: bus.io_rdata = buf_q[0];
      3'd1: bus.io_rdata = buf_q[1];
      3'd2: bus.io_rdata = buf_q[2];
      3'd3: bus.io_rdata = buf_q[3];
      3'd4: bus.io_rdata = {6'd0, lzb_q, raw_q};
      3'd5: bus.io_rdata = val_lo_q;
      3'd6: bus.io_rdata = val_hi_q;
      3'd7: bus.io_rdata = {6'd0, ovf_q, busy_q};
      default: bus.io_rdata = 8'd0;
    endcase
  end

  assign display_ctrl = raw_q;
  assign display_buf0 = buf_q[0];
  assign display_buf1 = buf_q[1];
  assign display_buf2 = buf_q[2];
  assign display_buf3 = buf_q[3];
  assign busy         = busy_q;
endmodule

// File: tb/tb_display_bcd_loader.sv
// Directed plus random bench for display_bcd_loader; expected digits come from decimal arithmetic.
module tb_display_bcd_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       display_ctrl;
  logic [7:0] display_buf0, display_buf1, display_buf2, display_buf3;
  logic       busy;
  int         total = 0;
  int         bad = 0;
  logic       m_lzb;
  logic       m_raw;

  display_bcd_loader_if bus_if ();

  display_bcd_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .display_ctrl (display_ctrl),
    .display_buf0 (display_buf0),
    .display_buf1 (display_buf1),
    .display_buf2 (display_buf2),
    .display_buf3 (display_buf3),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digit idx 0 is thousands, 3 is ones.
  function automatic logic [7:0] exp_code(input int v, input logic lzb, input int idx);
    int d[4];
    bit lead;
    if (v > 9999) return 8'h11;
    d[0] = v / 1000;
    d[1] = (v / 100) % 10;
    d[2] = (v / 10) % 10;
    d[3] = v % 10;
    lead = lzb;
    for (int i = 0; i <= idx; i++) if (d[i] != 0 || i == 3) lead = 0;
    return lead ? 8'h10 : d[idx][7:0];
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.io_addr  = a;
    bus_if.io_we    = 1'b1;
    bus_if.io_wdata = d;
    @(negedge clk);
    bus_if.io_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus_if.io_addr = a;
    #1;
    d = bus_if.io_rdata;
  endtask

  task automatic setctrl(input logic lzb, input logic raw);
    wr(3'd4, {6'd0, lzb, raw});
    m_lzb = lzb;
    m_raw = raw;
  endtask

  task automatic check_bufs(input string tag, input int v);
    chk({tag, "_buf0"}, display_buf0, exp_code(v, m_lzb, 0));
    chk({tag, "_buf1"}, display_buf1, exp_code(v, m_lzb, 1));
    chk({tag, "_buf2"}, display_buf2, exp_code(v, m_lzb, 2));
    chk({tag, "_buf3"}, display_buf3, exp_code(v, m_lzb, 3));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic convert(input string tag, input int v);
    logic [15:0] vv;
    logic        ovf_e;
    logic [7:0]  st;
    int          cyc;
    vv    = v[15:0];
    ovf_e = (v > 9999);
    wr(3'd5, vv[7:0]);
    wr(3'd6, vv[15:8]);
    rd(3'd7, st);
    chk({tag, "_status_start"}, st, {6'd0, ovf_e, 1'b1});
    wait_done(cyc);
    chk({tag, "_busy_cycles"}, cyc, ovf_e ? 1 : 17);
    m_raw = 1'b0;
    check_bufs(tag, v);
    chk({tag, "_ctrl"}, display_ctrl, m_raw);
    rd(3'd7, st);
    chk({tag, "_status_end"}, st, {6'd0, ovf_e, 1'b0});
  endtask

  initial begin
    logic [7:0] r;
    int         cyc;
    int         v;
    bus_if.io_addr  = 3'd0;
    bus_if.io_we    = 1'b0;
    bus_if.io_wdata = 8'd0;
    m_lzb = 1'b1;
    m_raw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_buf0", display_buf0, 8'h10);
    chk("rst_buf3", display_buf3, 8'h10);
    chk("rst_ctrl", display_ctrl, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rd(3'd7, r); chk("rst_status", r, 8'h00);
    rd(3'd4, r); chk("rst_ctrl_reg", r, 8'h02);

    @(negedge clk);
    wr(3'd2, 8'h5A);
    chk("direct_buf2", display_buf2, 8'h5A);
    rd(3'd2, r); chk("direct_buf2_rd", r, 8'h5A);
    @(negedge clk);
    wr(3'd7, 8'hFF);
    rd(3'd7, r); chk("addr7_write_noeffect", r, 8'h00);
    @(negedge clk);

    setctrl(1'b0, 1'b0);
    convert("v1234", 1234);
    setctrl(1'b1, 1'b0);
    convert("v7", 7);
    convert("v0", 0);
    convert("v9999", 9999);
    convert("v10000", 10000);
    convert("v5_ovfclr", 5);

    setctrl(1'b0, 1'b1);
    chk("raw_set", display_ctrl, 1'b1);
    convert("raw42", 42);

    // Conflicts mid-SHIFT: BUF/VAL_HI dropped, VAL_LO and CTRL.lzb honoured.
    wr(3'd5, 8'h31);
    wr(3'd6, 8'h01);
    wr(3'd1, 8'hAA);
    wr(3'd6, 8'h00);
    wr(3'd5, 8'h77);
    wr(3'd4, 8'h02);
    m_lzb = 1'b1;
    chk("conflict_busy", busy, 1'b1);
    wait_done(cyc);
    chk("conflict_cycles", cyc, 13);
    m_raw = 1'b0;
    check_bufs("conflict305", 305);
    rd(3'd5, r); chk("conflict_val_lo", r, 8'h77);
    rd(3'd6, r); chk("conflict_val_hi", r, 8'h01);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      v = (i % 4 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 12000));
      setctrl(1'($urandom_range(0, 1)), 1'b0);
      convert($sformatf("rand%0d_v%0d", i, v), v);
      @(negedge clk);
    end

    // Reset during SHIFT aborts the conversion.
    setctrl(1'b0, 1'b1);
    wr(3'd5, 8'hD2);
    wr(3'd6, 8'h04);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_buf0", display_buf0, 8'h10);
    chk("midrst_buf2", display_buf2, 8'h10);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ctrl", display_ctrl, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("postrst_buf0", display_buf0, 8'h10);
    chk("postrst_buf1", display_buf1, 8'h10);
    chk("postrst_buf3", display_buf3, 8'h10);
    chk("postrst_busy", busy, 1'b0);
    rd(3'd7, r); chk("postrst_status", r, 8'h00);
    rd(3'd4, r); chk("postrst_ctrl_reg", r, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
